reset_sequencer_nch: RTL and testbench
======================================

// Module: reset_sequencer_nch
// PURPOSE
// - Parametrised successor to the 3-output reset controller. Merges NUM_SRC reset request
//   sources into NUM_CH synchronous reset outputs.
// - Per source: 2-FF synchroniser, then a glitch filter.
// - Reset pulses are stretched to at least STRETCH_CYCLES.
// - Channels are released in order 0..NUM_CH-1, STAGGER_CYCLES apart.
// - Sits at the top level between board/SoC reset sources and all clk-domain logic.
// PARAMETERS
// NUM_SRC         2   number of reset request sources (>=1)
// NUM_CH          3   number of sequenced reset outputs (>=1)
// FILT_CYCLES     4   consecutive synced-high cycles needed to accept a request (>=1)
// STRETCH_CYCLES  8   cycles from request removal to release of channel 0 (>=1)
// STAGGER_CYCLES  5   cycles between release of channel k-1 and channel k (>=1)
// PORTS
// clk           in   1        system clock
// i_rst         in   1        async active-high reset of this block
// i_rst_src     in   NUM_SRC  async reset requests, active-high (bit 0 = primary, bit 1 = aux)
// o_rst_sync    out  NUM_CH   sequenced resets, active-high; assert sync, release sync
// o_busy        out  1        1 while any channel is still held in reset
// o_rst_cause   out  NUM_SRC  sticky per-source cause flags (RST_CAUSE_EN only)
// i_cause_clr   in   1        clears o_rst_cause (RST_CAUSE_EN only)
// BEHAVIOUR
// - Clocking and reset: one clock, clk. Reset i_rst is asynchronous, active-high.
//   - i_rst=1 immediately forces o_rst_sync to all ones and o_busy to 1.
//   - It also clears the sync flops and filter counters, and sets FSM=STRETCH with cnt=0.
//   - On i_rst release, the normal power-on release sequence follows.
// - Filter (per source):
//   - cnt_k increments while synced bit is 1, saturating at FILT_CYCLES.
//   - cnt_k clears to 0 on any cycle where the synced bit is 0.
//   - filt_k = (cnt_k == FILT_CYCLES); req = OR of all filt_k.
// - Assert latency: let E0 be the first edge that samples i_rst_src[k]=1, held high.
//   - o_rst_sync goes all ones at edge E0+FILT_CYCLES+2.
//   - A pulse spanning fewer than FILT_CYCLES sampling edges never reaches req.
// - FSM states:
//   - IDLE: all outputs 0, o_busy=0.
//   - ASSERT: all outputs 1.
//   - STRETCH: all outputs 1; cnt counts 0..STRETCH_CYCLES-1.
//   - RELEASE: channel index ch and cnt step the release.
// - Transitions:
//   - IDLE -> ASSERT when req=1.
//   - ASSERT -> STRETCH when req=0 (cnt=0).
//   - STRETCH at cnt==STRETCH_CYCLES-1 -> next edge drives o_rst_sync[0]=0. Then:
//     - if NUM_CH==1: go to IDLE;
//     - otherwise: go to RELEASE with ch=1, cnt=0.
//   - RELEASE at cnt==STAGGER_CYCLES-1 -> next edge drives o_rst_sync[ch]=0.
//     - ch==NUM_CH-1: go to IDLE.
//     - otherwise: ch++, cnt=0.
// - req=1 in STRETCH or RELEASE:
//   - next edge re-asserts ALL channels to 1 and goes to ASSERT;
//   - the sequence restarts in full.
// - Release order is strictly ascending:
//   - o_rst_sync[k]=0 implies o_rst_sync[j]=0 for all j<k;
//   - outputs never glitch.
// - o_busy = (state != IDLE), registered with the outputs. It equals |o_rst_sync.
// - Counter widths: $clog2(max(FILT_CYCLES, STRETCH_CYCLES, STAGGER_CYCLES)+1). No wrap; all compares are exact.
// CONFIGURATION
// - RST_CAUSE_EN defined:
//   - o_rst_cause[k] is set on the cycle filt_k rises, and held until i_cause_clr=1.
//   - Set wins over a clear in the same cycle.
//   - Cleared to 0 by i_rst.
//   - i_cause_clr and o_rst_cause ports exist.
// - RST_CAUSE_EN undefined:
//   - both ports and the cause register are absent;
//   - all other behaviour is identical.
// TESTING (defaults unless stated)
// 1. i_rst pulse, sources 0 -> outputs 3'b111 asynchronously.
//    - After release: ch0 low 8 edges later, ch1 5 edges after that, ch2 5 after that; o_busy falls with ch2.
// 2. i_rst_src[0] high for 3 clk periods in IDLE -> o_rst_sync stays 3'b000, o_busy stays 0.
// 3. i_rst_src[1] high for 20 periods -> 3'b111 at E0+6; held through the pulse.
//    - Then staggered 8/5/5 release as in test 1.
// 4. New 10-cycle request on src0 while ch0 already released and ch1 still pending ->
//    - all channels back to 1 on the edge after req;
//    - a full 8/5/5 release follows.
// 5. Both sources asserted with overlapping windows -> a single sequence.
//    - Release timing is measured from the later source's removal.
// 6. RST_CAUSE_EN: src1 request -> o_rst_cause=2'b10.
//    - i_cause_clr pulse -> 2'b00.
//    - Clear coincident with a new filt_1 rise -> stays 2'b10.

Source files
------------

// File: rtl/reset_sequencer_nch.sv
// Merges NUM_SRC async reset requests into NUM_CH staggered synchronous reset outputs.
// Optional sticky per-source cause flags are built when RST_CAUSE_EN is defined.
module reset_sequencer_nch #(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned FILT_CYCLES    = 4,
  parameter int unsigned STRETCH_CYCLES = 8,
  parameter int unsigned STAGGER_CYCLES = 5
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_rst_src,
  output logic [NUM_CH-1:0]  o_rst_sync,
  output logic               o_busy
`ifdef RST_CAUSE_EN
  ,
  input  logic               i_cause_clr,
  output logic [NUM_SRC-1:0] o_rst_cause
`endif
);

  localparam int unsigned MAX_A   = (FILT_CYCLES > STRETCH_CYCLES) ? FILT_CYCLES : STRETCH_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > STAGGER_CYCLES) ? MAX_A : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StAssert, StStretch, StRelease} state_t;

  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]   filt_cnt_q [NUM_SRC];
  logic [NUM_SRC-1:0] filt;
  logic               req;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]  rst_q, rst_d;
  logic               busy_q, busy_d;

  // Two-flop synchroniser followed by a saturating run-length filter per source
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int k = 0; k < NUM_SRC; k++) filt_cnt_q[k] <= '0;
    end else begin
      sync1_q <= i_rst_src;
      sync2_q <= sync1_q;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!sync2_q[k]) begin
          filt_cnt_q[k] <= '0;
        end else if (filt_cnt_q[k] != CNT_W'(FILT_CYCLES)) begin
          filt_cnt_q[k] <= filt_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) filt[k] = (filt_cnt_q[k] == CNT_W'(FILT_CYCLES));
  end

  assign req = |filt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rst_d   = rst_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StAssert;
          rst_d   = '1;
        end
      end
      StAssert: begin
        rst_d = '1;
        if (!req) begin
          state_d = StStretch;
          cnt_d   = '0;
        end
      end
      StStretch: begin
        if (req) begin
          state_d = StAssert;
          rst_d   = '1;
        end else if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          if (NUM_CH == 1) begin
            state_d = StIdle;
          end else begin
            state_d = StRelease;
            ch_d    = CH_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRelease: begin
        if (req) begin
          state_d = StAssert;
          rst_d   = '1;
        end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          for (int j = 0; j < NUM_CH; j++) begin
            if (ch_q == CH_W'(j)) rst_d[j] = 1'b0;
          end
          cnt_d = '0;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = StIdle;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StAssert;
        rst_d   = '1;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // Reset lands in STRETCH so a power-on release sequence follows i_rst removal
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StStretch;
      cnt_q   <= '0;
      ch_q    <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rst_sync = rst_q;
  assign o_busy     = busy_q;

`ifdef RST_CAUSE_EN
  logic [NUM_SRC-1:0] filt_q, cause_q;

  // A rising filter output sets its flag and wins over a simultaneous clear
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      filt_q  <= '0;
      cause_q <= '0;
    end else begin
      filt_q  <= filt;
      cause_q <= (cause_q & ~{NUM_SRC{i_cause_clr}}) | (filt & ~filt_q);
    end
  end

  assign o_rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer_nch.sv
// Self-checking bench for reset_sequencer_nch: expected output transitions are queued
// with their cycle number when stimulus is driven and checked every cycle.
module tb_reset_sequencer_nch;

  logic       clk;
  logic       i_rst;
  logic [1:0] i_rst_src;
  logic [2:0] o_rst_sync;
  logic       o_busy;
`ifdef RST_CAUSE_EN
  logic       i_cause_clr;
  logic [1:0] o_rst_cause;
`endif

  reset_sequencer_nch #(
    .NUM_SRC       (2),
    .NUM_CH        (3),
    .FILT_CYCLES   (4),
    .STRETCH_CYCLES(8),
    .STAGGER_CYCLES(5)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_rst_src  (i_rst_src),
    .o_rst_sync (o_rst_sync),
    .o_busy     (o_busy)
`ifdef RST_CAUSE_EN
    ,
    .i_cause_clr(i_cause_clr),
    .o_rst_cause(o_rst_cause)
`endif
  );

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ev_t;

  ev_t        sb[$];
  logic [2:0] exp_rst;
  int         cyc;
  int         n_cmp;
  int         n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and retire any transition due at this cycle
  task automatic tick();
    ev_t e;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      exp_rst = e.val;
    end
  endtask

  task automatic test_reset();
    int r;
    tick();
    tick();
    n_cmp++;
    if (o_rst_sync !== 3'b111 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold cyc=%0d rst=%b busy=%b want rst=111 busy=1", cyc, o_rst_sync,
               o_busy);
    end
    tick();
    i_rst = 1'b0;
    r = cyc;
    push(r + 8, 3'b110);
    push(r + 13, 3'b100);
    push(r + 18, 3'b000);
    for (int i = 0; i < 22; i++) begin
      tick();
      n_cmp++;
      if (o_rst_sync !== exp_rst || o_busy !== (|exp_rst)) begin
        n_err++;
        $display("FAIL por_release cyc=%0d rst=%b busy=%b want rst=%b busy=%b", cyc - r,
                 o_rst_sync, o_busy, exp_rst, |exp_rst);
      end
    end
    // Mid-cycle assertion must show up before the next rising edge
    #2 i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_rst_sync !== 3'b111 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL async_assert rst=%b busy=%b want rst=111 busy=1", o_rst_sync, o_busy);
    end
    exp_rst = 3'b111;
    tick();
    i_rst = 1'b0;
    r = cyc;
    push(r + 8, 3'b110);
    push(r + 13, 3'b100);
    push(r + 18, 3'b000);
    for (int i = 0; i < 22; i++) begin
      tick();
      n_cmp++;
      if (o_rst_sync !== exp_rst || o_busy !== (|exp_rst)) begin
        n_err++;
        $display("FAIL rst_release cyc=%0d rst=%b busy=%b want rst=%b busy=%b", cyc - r,
                 o_rst_sync, o_busy, exp_rst, |exp_rst);
      end
    end
`ifdef RST_CAUSE_EN
    n_cmp++;
    if (o_rst_cause !== 2'b00) begin
      n_err++;
      $display("FAIL cause_reset got=%b want=00", o_rst_cause);
    end
`endif
  endtask

  task automatic test_glitch();
    int n;
    tick();
    n = cyc;
    i_rst_src[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cyc == n + 3) i_rst_src[0] = 1'b0;
      n_cmp++;
      if (o_rst_sync !== exp_rst || o_busy !== (|exp_rst)) begin
        n_err++;
        $display("FAIL glitch cyc=%0d rst=%b busy=%b want rst=%b busy=%b", cyc - n,
                 o_rst_sync, o_busy, exp_rst, |exp_rst);
      end
    end
  endtask

  task automatic test_stretch();
    int n;
    tick();
    n = cyc;
    i_rst_src[1] = 1'b1;
    push(n + 7, 3'b111);
    push(n + 32, 3'b110);
    push(n + 37, 3'b100);
    push(n + 42, 3'b000);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cyc == n + 20) i_rst_src[1] = 1'b0;
      n_cmp++;
      if (o_rst_sync !== exp_rst || o_busy !== (|exp_rst)) begin
        n_err++;
        $display("FAIL stretch cyc=%0d rst=%b busy=%b want rst=%b busy=%b", cyc - n,
                 o_rst_sync, o_busy, exp_rst, |exp_rst);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL stretch_drain pending=%0d want=0", sb.size());
    end
  endtask

  task automatic test_retrigger();
    int n;
    tick();
    n = cyc;
    i_rst_src[1] = 1'b1;
    push(n + 7, 3'b111);
    push(n + 18, 3'b110);
    push(n + 21, 3'b111);
    push(n + 36, 3'b110);
    push(n + 41, 3'b100);
    push(n + 46, 3'b000);
    for (int i = 0; i < 55; i++) begin
      tick();
      if (cyc == n + 6) i_rst_src[1] = 1'b0;
      if (cyc == n + 14) i_rst_src[0] = 1'b1;
      if (cyc == n + 24) i_rst_src[0] = 1'b0;
      n_cmp++;
      if (o_rst_sync !== exp_rst || o_busy !== (|exp_rst)) begin
        n_err++;
        $display("FAIL retrigger cyc=%0d rst=%b busy=%b want rst=%b busy=%b", cyc - n,
                 o_rst_sync, o_busy, exp_rst, |exp_rst);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL retrigger_drain pending=%0d want=0", sb.size());
    end
  endtask

  task automatic test_overlap();
    int n;
    tick();
    n = cyc;
    i_rst_src[0] = 1'b1;
    push(n + 7, 3'b111);
    push(n + 37, 3'b110);
    push(n + 42, 3'b100);
    push(n + 47, 3'b000);
    for (int i = 0; i < 55; i++) begin
      tick();
      if (cyc == n + 5) i_rst_src[1] = 1'b1;
      if (cyc == n + 15) i_rst_src[0] = 1'b0;
      if (cyc == n + 25) i_rst_src[1] = 1'b0;
      n_cmp++;
      if (o_rst_sync !== exp_rst || o_busy !== (|exp_rst)) begin
        n_err++;
        $display("FAIL overlap cyc=%0d rst=%b busy=%b want rst=%b busy=%b", cyc - n,
                 o_rst_sync, o_busy, exp_rst, |exp_rst);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL overlap_drain pending=%0d want=0", sb.size());
    end
  endtask

`ifdef RST_CAUSE_EN
  task automatic test_cause();
    int n;
    tick();
    i_cause_clr = 1'b1;
    tick();
    i_cause_clr = 1'b0;
    n_cmp++;
    if (o_rst_cause !== 2'b00) begin
      n_err++;
      $display("FAIL cause_clr0 got=%b want=00", o_rst_cause);
    end
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      n = cyc;
      i_rst_src[1] = 1'b1;
      push(n + 7, 3'b111);
      push(n + 20, 3'b110);
      push(n + 25, 3'b100);
      push(n + 30, 3'b000);
      for (int i = 0; i < 35; i++) begin
        tick();
        if (cyc == n + 8) i_rst_src[1] = 1'b0;
        // Second pass: clear lands on the same edge that captures the filter rise
        if (pass == 1 && cyc == n + 6) i_cause_clr = 1'b1;
        if (pass == 1 && cyc == n + 7) i_cause_clr = 1'b0;
        n_cmp++;
        if (o_rst_sync !== exp_rst || o_busy !== (|exp_rst)) begin
          n_err++;
          $display("FAIL cause_seq cyc=%0d rst=%b busy=%b want rst=%b busy=%b", cyc - n,
                   o_rst_sync, o_busy, exp_rst, |exp_rst);
        end
      end
      n_cmp++;
      if (o_rst_cause !== 2'b10) begin
        n_err++;
        $display("FAIL cause_set pass=%0d got=%b want=10", pass, o_rst_cause);
      end
      if (pass == 0) begin
        i_cause_clr = 1'b1;
        tick();
        i_cause_clr = 1'b0;
        n_cmp++;
        if (o_rst_cause !== 2'b00) begin
          n_err++;
          $display("FAIL cause_clr1 got=%b want=00", o_rst_cause);
        end
      end
    end
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_rst   = 3'b111;
    i_rst     = 1'b1;
    i_rst_src = 2'b00;
`ifdef RST_CAUSE_EN
    i_cause_clr = 1'b0;
`endif
    test_reset();
    test_glitch();
    test_stretch();
    test_retrigger();
    test_overlap();
`ifdef RST_CAUSE_EN
    test_cause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
